// File: rtl/fwd_ctrl_if.sv
// Decode-stage operand-forwarding bundle: ID instruction fields in, EX operand selects and stall out.
interface fwd_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_wen;
  logic             id_is_load;
  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_wen, id_is_load,
    input  fwd_sel_a, fwd_sel_b, stall, stall_count
  );

  modport slave (
    input  hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_wen, id_is_load,
    output fwd_sel_a, fwd_sel_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the EX-stage operand muxes.
// Tracks EX/MEM producers, registers the operand selects for the consumer's EX cycle.
module fwd_ctrl (
  input  logic        clk,
  input  logic        reset,
  fwd_ctrl_if.slave   bus
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b10;

  logic             ex_valid_q, ex_valid_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             ex_load_q, ex_load_d;
  logic             mem_valid_q;
  logic [REG_W-1:0] mem_rd_q;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic hazard, stall_c;

  // x0 is hardwired zero, so it never matches a producer
  function automatic logic src_match(input logic             used,
                                     input logic             slot_valid,
                                     input logic [REG_W-1:0] slot_rd,
                                     input logic [REG_W-1:0] rs);
    return used & slot_valid & (slot_rd == rs) & (rs != '0);
  endfunction

  // Hazard detection, next selects and next slot contents
  always_comb begin
    ex_m1   = src_match(bus.id_rs1_used, ex_valid_q,  ex_rd_q,  bus.id_rs1);
    ex_m2   = src_match(bus.id_rs2_used, ex_valid_q,  ex_rd_q,  bus.id_rs2);
    mem_m1  = src_match(bus.id_rs1_used, mem_valid_q, mem_rd_q, bus.id_rs1);
    mem_m2  = src_match(bus.id_rs2_used, mem_valid_q, mem_rd_q, bus.id_rs2);
    hazard  = bus.id_valid & ex_load_q & (ex_m1 | ex_m2);
    stall_c = hazard & ~bus.flush;

    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    // EX producer is newer than MEM, so it wins when both match
    if (!(stall_c || bus.flush)) begin
      if (ex_m1 && !ex_load_q) sel_a_d = SEL_EXMEM;
      else if (mem_m1)         sel_a_d = SEL_MEMWB;
      if (ex_m2 && !ex_load_q) sel_b_d = SEL_EXMEM;
      else if (mem_m2)         sel_b_d = SEL_MEMWB;
    end

    ex_valid_d = bus.id_valid & bus.id_wen & ~stall_c & ~bus.flush;
    ex_rd_d    = bus.id_rd;
    ex_load_d  = bus.id_is_load;

    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Pipeline slots, select registers and stall counter; frozen while hold is set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
    end else if (!bus.hold) begin
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_load_q   <= ex_load_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.fwd_sel_a   = sel_a_q;
  assign bus.fwd_sel_b   = sel_b_q;
  assign bus.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed hazard sequences plus random traffic
// checked against a producer-history reference model.
module tb_fwd_ctrl;
  logic clk = 1'b0;
  logic reset;

  fwd_ctrl_if bus ();

  fwd_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          stall;
    bit [1:0]    sa;
    bit [1:0]    sb;
    int unsigned cnt;
  } exp_t;

  typedef struct {
    bit       wr;
    bit [4:0] rd;
    bit       ld;
  } prod_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the two most recent instructions to leave ID (newest first)
  prod_t       m_ex, m_mem;
  bit [1:0]    m_sa, m_sb;
  int unsigned m_cnt;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic bit fwdable(input prod_t p, input bit used, input bit [4:0] rs);
    return p.wr && used && (rs != 5'd0) && (p.rd == rs);
  endfunction

  // Newest producer wins; a load still in EX cannot supply its value yet
  function automatic bit [1:0] pick(input bit used, input bit [4:0] rs);
    if (fwdable(m_ex, used, rs) && !m_ex.ld) return 2'd1;
    if (fwdable(m_mem, used, rs)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    return bus.id_valid && !bus.flush && m_ex.ld &&
           (fwdable(m_ex, bus.id_rs1_used, bus.id_rs1) ||
            fwdable(m_ex, bus.id_rs2_used, bus.id_rs2));
  endfunction

  function automatic void m_reset();
    m_ex  = '{wr: 1'b0, rd: 5'd0, ld: 1'b0};
    m_mem = '{wr: 1'b0, rd: 5'd0, ld: 1'b0};
    m_sa  = 2'd0;
    m_sb  = 2'd0;
    m_cnt = 0;
  endfunction

  function automatic void m_edge();
    bit st;
    if (bus.hold) return;
    st = m_stall();
    if (st || bus.flush) begin
      m_sa = 2'd0;
      m_sb = 2'd0;
    end else begin
      m_sa = pick(bus.id_rs1_used, bus.id_rs1);
      m_sb = pick(bus.id_rs2_used, bus.id_rs2);
    end
    if (st && m_cnt < 65535) m_cnt++;
    m_mem = m_ex;
    m_ex  = '{wr: bus.id_valid && bus.id_wen && !st && !bus.flush,
              rd: bus.id_rd, ld: bus.id_is_load};
  endfunction

  task automatic drive(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                       input bit u2, input bit [4:0] rd, input bit w, input bit ld,
                       input bit fl, input bit hd);
    exp_t e;
    bus.id_valid    = v;
    bus.id_rs1      = r1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = r2;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_wen      = w;
    bus.id_is_load  = ld;
    bus.flush       = fl;
    bus.hold        = hd;
    e.stall = m_stall();
    e.sa    = m_sa;
    e.sb    = m_sb;
    e.cnt   = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                      input bit u2, input bit [4:0] rd, input bit w, input bit ld,
                      input bit fl, input bit hd);
    drive(v, r1, u1, r2, u2, rd, w, ld, fl, hd);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic alu(input bit [4:0] rd, input bit [4:0] r1, input bit [4:0] r2);
    step(1'b1, r1, 1'b1, r2, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input bit [4:0] rd, input bit [4:0] r1);
    step(1'b1, r1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sel_is(input string name, input int unsigned a, input int unsigned b);
    check({name, "_sel_a"}, 32'(bus.fwd_sel_a), a);
    check({name, "_sel_b"}, 32'(bus.fwd_sel_b), b);
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_stall", 32'(bus.stall), 32'(e.stall));
        check("sb_sel_a", 32'(bus.fwd_sel_a), 32'(e.sa));
        check("sb_sel_b", 32'(bus.fwd_sel_b), 32'(e.sb));
        check("sb_count", 32'(bus.stall_count), e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.hold = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.id_rd = '0; bus.id_wen = 1'b0; bus.id_is_load = 1'b0;
    m_reset();
    #2;
    check("reset_stall", 32'(bus.stall), 0);
    sel_is("reset", 0, 0);
    check("reset_count", 32'(bus.stall_count), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ALU back-to-back: add x5; sub x6,x5,x7
    idle();
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd6, 5'd5, 5'd7);
    sel_is("b2b", 1, 0);

    // Distance two: add x5; unrelated; or x8,x1,x5
    idle(); idle();
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd9, 5'd1, 5'd2);
    alu(5'd8, 5'd1, 5'd5);
    sel_is("dist2", 0, 2);

    // Both slots write x5, newer wins; x0 is never forwarded
    idle(); idle();
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd5, 5'd3, 5'd4);
    alu(5'd3, 5'd5, 5'd0);
    sel_is("newer", 1, 0);
    alu(5'd0, 5'd1, 5'd2);
    alu(5'd3, 5'd0, 5'd0);
    sel_is("x0", 0, 0);

    // Load-use: lw x5; add x6,x5,x5 -> one bubble, then MEM/WB forwarding
    idle(); idle();
    load(5'd5, 5'd1);
    alu(5'd6, 5'd5, 5'd5);
    check("lu_count", 32'(bus.stall_count), 1);
    alu(5'd6, 5'd5, 5'd5);
    sel_is("lu", 2, 2);
    check("lu_count_once", 32'(bus.stall_count), 1);

    // Flush coincident with a hazard: no stall, selects cleared, bubble in EX
    idle(); idle();
    load(5'd5, 5'd1);
    step(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    sel_is("flush", 0, 0);
    alu(5'd7, 5'd5, 5'd5);
    sel_is("post_flush", 2, 2);
    check("flush_count", 32'(bus.stall_count), 1);

    // Hold for three cycles while a load-use hazard is pending
    idle(); idle();
    load(5'd7, 5'd1);
    repeat (3) step(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("hold_count", 32'(bus.stall_count), 1);
    alu(5'd1, 5'd7, 5'd2);
    check("hold_release_count", 32'(bus.stall_count), 2);
    alu(5'd1, 5'd7, 5'd2);
    sel_is("hold_lu", 2, 0);

    // Random traffic over a small register set to provoke matches
    repeat (400) begin
      bit       v, u1, u2, w, ld, fl, hd;
      bit [4:0] r1, r2, rd;
      v  = ($urandom_range(0, 7) != 0);
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      u1 = ($urandom_range(0, 3) != 0);
      u2 = ($urandom_range(0, 1) != 0);
      w  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 7) == 0);
      hd = ($urandom_range(0, 7) == 0);
      step(v, r1, u1, r2, u2, rd, w, ld, fl, hd);
    end

    // Asynchronous reset in the middle of a load-use stall
    idle();
    load(5'd5, 5'd1);
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_stall", 32'(bus.stall), 0);
    sel_is("rst", 0, 0);
    check("rst_count", 32'(bus.stall_count), 0);
    @(posedge clk);
    m_reset();
    #1 reset = 1'b0;
    alu(5'd6, 5'd5, 5'd5);

    // Saturation: preload the counter near the top, then force more stalls
    force dut.stall_cnt_q = 16'hFFFD;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFD;
    repeat (4) begin
      load(5'd5, 5'd1);
      alu(5'd6, 5'd5, 5'd5);
    end
    check("sat_count", 32'(bus.stall_count), 32'hFFFF);
    idle();

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
